bcd_converter: RTL and testbench
================================

BCD_CONVERTER -- requirements
Module: bcd_converter

Interface
REQ-001 Parameter IN_W, default 16: width of the binary input value.
REQ-002 Parameter NDIG, default 5: number of BCD digits produced; NDIG SHALL satisfy 10^NDIG > 2^IN_W - 1.
REQ-003 Parameter BLANK_LZ, default 1: 1 = blank leading zeros, 0 = show all digits.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset is synchronous and active-high.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_data  input  IN_W  unsigned binary value to convert.
REQ-008 in_ready  output  1  block can accept a new value this cycle.
REQ-009 bcd_out  output  4*NDIG  digit i in bits [4i+3:4i]; digit 0 is least significant; each nibble drives one seven-segment digit decoder.
REQ-010 out_valid  output  1  one-cycle pulse: bcd_out updated with a new result.
REQ-011 busy  output  1  a conversion is in progress (state SHIFT or DONE).

Function
REQ-012 The block SHALL implement states IDLE, SHIFT and DONE.
REQ-013 in_ready SHALL equal 1 exactly when state is IDLE.
REQ-014 Accept: at an edge with in_valid=1 and in_ready=1, the block SHALL latch in_data into a shift register, clear an NDIG*4-bit BCD accumulator, load a bit counter with IN_W, and enter SHIFT.
REQ-015 In SHIFT, each edge SHALL first add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left by one bit, then decrement the counter (double-dabble).
REQ-016 After exactly IN_W SHIFT edges the block SHALL enter DONE; no counter wrap-around, and no extra or missing shift.
REQ-017 At the DONE edge the block SHALL load bcd_out from the accumulator (after blanking per REQ-019), set out_valid=1 for exactly one cycle, and return to IDLE.
REQ-018 Latency: if accepted at edge T, bcd_out and out_valid SHALL change at edge T+IN_W+1; the earliest next accept is edge T+IN_W+2 (18 cycles per conversion at default width).
REQ-019 With BLANK_LZ=1, digit i (i >= 1) SHALL be output as 4'hF when it and all higher digits are zero; digit 0 SHALL never be blanked. With BLANK_LZ=0, no blanking SHALL occur.
REQ-020 in_valid and in_data SHALL be ignored while state is not IDLE; the conversion in progress SHALL be unaffected.
REQ-021 bcd_out SHALL hold its last value between conversions and SHALL change only at a DONE edge or on reset.
REQ-022 Every digit produced SHALL be in the range 0-9 or 4'hF (blank); no other codes SHALL appear on bcd_out.

Reset
REQ-023 While reset=1 at an edge: state SHALL become IDLE, counter 0, accumulator 0, out_valid 0, busy 0, and every bcd_out digit 4'hF (blank display).
REQ-024 A reset during SHIFT or DONE SHALL abandon the conversion with no out_valid pulse; in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-025 Reset SHALL take priority over an accept that occurs on the same edge.

Verification
REQ-026 in_data=0 accepted -> after 17 cycles bcd_out = F,F,F,F,0 (digit 4..0), out_valid high one cycle.
REQ-027 in_data=12345 -> bcd_out = 1,2,3,4,5; in_data=65535 -> 6,5,5,3,5; in_data=9 -> F,F,F,F,9.
REQ-028 BLANK_LZ=0, in_data=1000 -> bcd_out = 0,1,0,0,0.
REQ-029 in_data=42 accepted, then in_valid=1 with in_data=777 held through SHIFT -> result F,F,F,4,2; in_ready low for 17 cycles; 777 accepted only once in_ready returns to 1.
REQ-030 Reset asserted at SHIFT cycle 8 of a conversion of 500 -> no out_valid, bcd_out all F, in_ready=1 the cycle after reset deasserts; a following conversion of 500 yields F,F,5,0,0.
REQ-031 Back-to-back accepts of 1, 2, 3 with in_valid held high -> out_valid pulses exactly 18 cycles apart with results in order.

Source files
------------

// File: rtl/bcd_converter_if.sv
// rtl/bcd_converter_if.sv - handshake and result bundle for bcd_converter
//
// Ports (slave = converter side):
//   in_valid  in   : in_data is valid this cycle
//   in_data   in   : unsigned binary value, IN_W bits
//   in_ready  out  : converter can accept a value this cycle
//   bcd_out   out  : NDIG packed BCD nibbles, digit 0 in bits [3:0]
//   out_valid out  : one-cycle pulse when bcd_out carries a new result
//   busy      out  : conversion in progress
interface bcd_converter_if #(
   parameter int IN_W = 16,
   parameter int NDIG = 5
);
   logic              in_valid;
   logic [IN_W-1:0]   in_data;
   logic              in_ready;
   logic [4*NDIG-1:0] bcd_out;
   logic              out_valid;
   logic              busy;

   modport master (
      output in_valid, in_data,
      input  in_ready, bcd_out, out_valid, busy
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, bcd_out, out_valid, busy
   );
endinterface

// File: rtl/bcd_converter.sv
// rtl/bcd_converter.sv - sequential double-dabble binary to BCD converter
//
// Ports:
//   clk_i    : sole clock, rising edge
//   reset_i  : synchronous active-high reset
//   bus_if   : bcd_converter_if.slave (accept handshake, BCD result, busy)
// One conversion takes IN_W shift cycles plus one DONE cycle; a new value is
// only accepted in IDLE.
module bcd_converter #(
   parameter int IN_W     = 16,
   parameter int NDIG     = 5,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic            clk_i,
   input  logic            reset_i,
   bcd_converter_if.slave  bus_if
);
   localparam int CNT_W = $clog2(IN_W + 1);
   localparam int ACC_W = 4 * NDIG;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IN_W-1:0]  sh_q, sh_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] bcd_q, bcd_d;
   logic             vld_q, vld_d;
   logic [ACC_W-1:0] acc_adj;
   logic [ACC_W-1:0] acc_fmt;

   // Double-dabble correction: any digit >= 5 would overflow past 9 when
   // doubled, so pre-add 3 to carry it into the next digit after the shift.
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < NDIG; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Leading-zero blanking: walk from the top digit down while digits are
   // zero; digit 0 is never blanked so a value of zero still shows "0".
   always_comb begin
      logic lead;
      acc_fmt = acc_q;
      lead    = 1'b1;
      for (int i = NDIG - 1; i >= 1; i--) begin
         if (lead && (acc_q[4*i +: 4] == 4'd0)) begin
            if (BLANK_LZ) begin
               acc_fmt[4*i +: 4] = 4'hF;
            end
         end else begin
            lead = 1'b0;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      bcd_d   = bcd_q;
      vld_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus_if.in_valid) begin
               sh_d    = bus_if.in_data;
               acc_d   = '0;
               cnt_d   = CNT_W'(IN_W);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            acc_d = {acc_adj[ACC_W-2:0], sh_q[IN_W-1]};
            sh_d  = {sh_q[IN_W-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            // The edge that consumes the last bit moves straight to DONE.
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bcd_d   = acc_fmt;
            vld_d   = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         acc_q   <= '0;
         bcd_q   <= {NDIG{4'hF}};
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         bcd_q   <= bcd_d;
         vld_q   <= vld_d;
      end
   end

   assign bus_if.in_ready  = (state_q == IDLE);
   assign bus_if.busy      = (state_q == SHIFT) || (state_q == DONE);
   assign bus_if.bcd_out   = bcd_q;
   assign bus_if.out_valid = vld_q;
endmodule

// File: tb/tb_bcd_converter.sv
// tb/tb_bcd_converter.sv - self-checking bench for bcd_converter
module tb_bcd_converter;
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [15:0] in_data;
   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned cyc     = 0;
   logic [19:0] last_a, last_b;

   bcd_converter_if #(.IN_W(16), .NDIG(5)) bus_a ();
   bcd_converter_if #(.IN_W(16), .NDIG(5)) bus_b ();

   assign bus_a.in_valid = in_valid;
   assign bus_a.in_data  = in_data;
   assign bus_b.in_valid = in_valid;
   assign bus_b.in_data  = in_data;

   bcd_converter #(.IN_W(16), .NDIG(5), .BLANK_LZ(1'b1)) dut_a (
      .clk_i   (clk),
      .reset_i (reset),
      .bus_if  (bus_a)
   );

   bcd_converter #(.IN_W(16), .NDIG(5), .BLANK_LZ(1'b0)) dut_b (
      .clk_i   (clk),
      .reset_i (reset),
      .bus_if  (bus_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Decimal digits by division; blanked digits are those beyond the number
   // of significant decimal digits of v (zero has one significant digit).
   function automatic logic [19:0] ref_bcd(input int v, input bit blank);
      logic [19:0] r;
      int sig;
      int t;
      int p;
      sig = 1;
      t   = v;
      while (t >= 10) begin
         t = t / 10;
         sig++;
      end
      p = 1;
      r = '0;
      for (int i = 0; i < 5; i++) begin
         if (blank && i >= sig) r[4*i +: 4] = 4'hF;
         else                   r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   // Called at a negedge while the converter is idle; returns at the negedge
   // where out_valid is seen (or after a bounded wait).
   task automatic run_conv(input logic [15:0] v, input bit hold, input logic [15:0] nxt,
                           output int unsigned t_pulse);
      int k;
      in_valid = 1'b1;
      in_data  = v;
      check("ready_before", 32'(bus_a.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = hold;
      in_data  = nxt;
      k = 0;
      check("busy_start", 32'(bus_a.busy), 32'd1);
      check("ready_start", 32'(bus_a.in_ready), 32'd0);
      check("pulse_width", 32'(bus_a.out_valid), 32'd0);
      while (!bus_a.out_valid && k < 40) begin
         @(negedge clk);
         k++;
         if (k == 16) begin
            check("ready_mid", 32'(bus_b.in_ready), 32'd0);
            check("bcd_hold_a", 32'(bus_a.bcd_out), 32'(last_a));
            check("bcd_hold_b", 32'(bus_b.bcd_out), 32'(last_b));
         end
      end
      check("latency", 32'(k), 32'd17);
      check("pulse_b", 32'(bus_b.out_valid), 32'd1);
      check("bcd_a", 32'(bus_a.bcd_out), 32'(ref_bcd(int'(v), 1'b1)));
      check("bcd_b", 32'(bus_b.bcd_out), 32'(ref_bcd(int'(v), 1'b0)));
      check("ready_after", 32'(bus_a.in_ready), 32'd1);
      last_a  = ref_bcd(int'(v), 1'b1);
      last_b  = ref_bcd(int'(v), 1'b0);
      t_pulse = cyc;
   endtask

   initial begin
      int unsigned t0, t1, t2;
      int pulses;
      logic [15:0] dir_vals [6];
      dir_vals = '{16'd0, 16'd9, 16'd12345, 16'd65535, 16'd1000, 16'd42};

      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(bus_a.in_ready), 32'd1);
      check("rst_busy", 32'(bus_a.busy), 32'd0);
      check("rst_valid", 32'(bus_a.out_valid), 32'd0);
      check("rst_bcd_a", 32'(bus_a.bcd_out), 32'hFFFFF);
      check("rst_bcd_b", 32'(bus_b.bcd_out), 32'hFFFFF);
      last_a = 20'hFFFFF;
      last_b = 20'hFFFFF;
      reset  = 1'b0;
      @(negedge clk);

      foreach (dir_vals[i]) run_conv(dir_vals[i], 1'b0, 16'd0, t0);

      // New request held through a conversion must not disturb it.
      run_conv(16'd42, 1'b1, 16'd777, t0);
      run_conv(16'd777, 1'b0, 16'd0, t0);

      // Back-to-back accepts with in_valid held high.
      run_conv(16'd1, 1'b1, 16'd2, t0);
      run_conv(16'd2, 1'b1, 16'd3, t1);
      run_conv(16'd3, 1'b0, 16'd0, t2);
      check("b2b_gap1", t1 - t0, 32'd18);
      check("b2b_gap2", t2 - t1, 32'd18);
      @(negedge clk);
      check("pulse_end", 32'(bus_a.out_valid), 32'd0);
      check("bcd_held", 32'(bus_a.bcd_out), 32'(ref_bcd(3, 1'b1)));

      // Reset in the middle of a conversion, then reset vs accept priority.
      in_valid = 1'b1;
      in_data  = 16'd500;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", 32'(bus_a.out_valid), 32'd0);
      check("mid_rst_busy", 32'(bus_a.busy), 32'd0);
      check("mid_rst_bcd", 32'(bus_a.bcd_out), 32'hFFFFF);
      in_valid = 1'b1;
      in_data  = 16'd123;
      @(negedge clk);
      check("rst_priority", 32'(bus_a.busy), 32'd0);
      in_valid = 1'b0;
      reset    = 1'b0;
      check("ready_post_rst", 32'(bus_a.in_ready), 32'd1);
      pulses = 0;
      repeat (25) begin
         @(negedge clk);
         if (bus_a.out_valid || bus_b.out_valid) pulses++;
      end
      check("no_pulse_after_rst", 32'(pulses), 32'd0);
      last_a = 20'hFFFFF;
      last_b = 20'hFFFFF;
      run_conv(16'd500, 1'b0, 16'd0, t0);

      repeat (20) run_conv(16'($urandom_range(0, 65535)), 1'b0, 16'd0, t0);
      repeat (10) run_conv(16'($urandom_range(0, 120)), 1'b0, 16'd0, t0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
